mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 17, RAM index width (RAM is 2^ADDR_WIDTH bytes).
REQ-002 Parameter IO_BASE, default 32'h0003_0000, lowest I/O-mapped byte address.
REQ-003 Parameter FIFO_DEPTH, default 8, output-byte FIFO entries (power of two, >=4).
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 mem_a  input  32  byte address from the memory controller.
REQ-007 mem_wr  input  1  1 = write mem_wdata at mem_a this cycle; 0 = read.
REQ-008 mem_wdata  input  8  write byte from the controller.
REQ-009 mem_rdata  output  8  registered read byte; it feeds the controller's mem_din.
REQ-010 io_buffer_full  output  1  output FIFO nearly full; the controller must not issue further I/O writes.
REQ-011 tx_byte  output  8  head byte of the output FIFO.
REQ-012 tx_valid  output  1  FIFO non-empty.
REQ-013 tx_ready  input  1  downstream sink accepts tx_byte this cycle.
REQ-014 overflow  output  1  sticky; an I/O byte was dropped.
REQ-015 sim_halt  output  1  sticky; a write to IO_BASE+4 occurred.

Function
REQ-016 Address decode: an address is I/O when mem_a >= IO_BASE; otherwise it is RAM at index mem_a[ADDR_WIDTH-1:0].
- Upper RAM address bits are ignored (aliasing).
REQ-017 RAM write: on posedge with mem_wr=1 and a RAM address, RAM[index] <= mem_wdata.
- mem_rdata is unchanged that cycle.
REQ-018 RAM read: on posedge with mem_wr=0 and a RAM address, mem_rdata <= RAM[index].
- Data is valid exactly one cycle after the address is presented (1-cycle latency).
- Back-to-back addresses on consecutive cycles yield back-to-back data.
REQ-019 I/O read: on posedge with mem_wr=0 and an I/O address, mem_rdata <= 8'h00.
REQ-020 I/O write to IO_BASE pushes mem_wdata into the FIFO.
- Push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
- Otherwise the byte is dropped and overflow <= 1.
REQ-021 I/O write to IO_BASE+4 sets sim_halt <= 1.
- The FIFO is not affected.
REQ-022 I/O writes to any other I/O address have no effect.
REQ-023 FIFO pop occurs when tx_valid && tx_ready; the head pointer advances modulo FIFO_DEPTH.
REQ-024 Count update:
- push only: +1
- pop only: -1
- push and pop in the same cycle: count unchanged, and both pointers advance.
REQ-025 tx_valid = (count != 0); tx_byte = entry at the head pointer.
- Both are combinational from registered state.
REQ-026 io_buffer_full = (count >= FIFO_DEPTH-2), combinational from count.
- The two spare entries absorb a write already in flight in the controller.
REQ-027 Pointer widths are log2(FIFO_DEPTH); count width is log2(FIFO_DEPTH)+1.
- Pointer wrap-around is natural modulo arithmetic.
REQ-028 An address of exactly IO_BASE-1 is RAM; an address of exactly IO_BASE is I/O.

Reset
REQ-029 While reset=1, asynchronously:
- mem_rdata=0, tx_valid=0, count=0, both pointers=0, overflow=0, sim_halt=0, io_buffer_full=0.
REQ-030 RAM contents and FIFO storage are not cleared by reset.
REQ-031 Reset during a FIFO drain discards all queued bytes; tx_valid is 0 on the first cycle after reset deasserts.

Verification
REQ-032 RAM read: write 8'hA5 to 0x0000_0010, then the next cycle read 0x10 -> mem_rdata=8'hA5 one cycle after the read address.
REQ-033 Byte order: write 0x11,0x22,0x33,0x44 to 0x100..0x103, then read 0x100..0x103 on consecutive cycles -> rdata 11,22,33,44 on consecutive cycles with 1-cycle lag.
REQ-034 FIFO fill: tx_ready=0, 6 writes to IO_BASE -> io_buffer_full rises after the 6th push (count=6).
- 2 more writes -> count=8.
- A 9th write -> dropped, overflow=1.
REQ-035 Simultaneous push/pop: count=8, tx_ready=1, write 8'h7E to IO_BASE -> count stays 8, no overflow, 8'h7E appears as the last byte drained.
REQ-036 Halt and reset: write to IO_BASE+4 -> sim_halt=1; I/O read of IO_BASE -> rdata=0.
- Assert reset mid-drain -> sim_halt=0, tx_valid=0, and previously written RAM bytes still read back correctly.

Source files
------------

// File: rtl/mem_responder.sv
// Byte-addressed RAM plus memory-mapped I/O responder: 1-cycle registered reads,
// an output-byte FIFO at IO_BASE and a sticky halt flag at IO_BASE+4.
module mem_responder #(
   parameter int unsigned ADDR_WIDTH = 17,
   parameter logic [31:0] IO_BASE    = 32'h0003_0000,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] mem_a,
   input  logic        mem_wr,
   input  logic [7:0]  mem_wdata,
   output logic [7:0]  mem_rdata,
   output logic        io_buffer_full,
   output logic [7:0]  tx_byte,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        overflow,
   output logic        sim_halt
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] FULL_C  = CW'(FIFO_DEPTH - 2);
   localparam logic [31:0]   HALT_A  = IO_BASE + 32'd4;

   logic [7:0] ram_q [2**ADDR_WIDTH];
   logic [7:0] fifo_q [FIFO_DEPTH];

   logic [7:0]    rdata_q, rdata_d;
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d, halt_q, halt_d;

   logic                  is_io, ram_we, push_req, push_ok, pop;
   logic [ADDR_WIDTH-1:0] ram_idx;

   always_comb begin
      is_io    = (mem_a >= IO_BASE);
      ram_idx  = mem_a[ADDR_WIDTH-1:0];
      ram_we   = mem_wr && !is_io;
      push_req = mem_wr && (mem_a == IO_BASE);
      pop      = (count_q != '0) && tx_ready;
      // A full FIFO still accepts a push when the head leaves in the same cycle.
      push_ok  = push_req && ((count_q < DEPTH_C) || pop);
   end

   always_comb begin
      rdata_d = rdata_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      halt_d  = halt_q;
      if (!mem_wr)
         rdata_d = is_io ? 8'h00 : ram_q[ram_idx];
      if (pop)
         head_d = head_q + PW'(1);
      if (push_ok)
         tail_d = tail_q + PW'(1);
      if (push_ok && !pop)
         count_d = count_q + CW'(1);
      else if (pop && !push_ok)
         count_d = count_q - CW'(1);
      if (push_req && !push_ok)
         ovf_d = 1'b1;
      if (mem_wr && (mem_a == HALT_A))
         halt_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         halt_q  <= 1'b0;
      end else begin
         rdata_q <= rdata_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         halt_q  <= halt_d;
      end
   end

   // Storage arrays are deliberately outside reset.
   always_ff @(posedge clk) begin
      if (ram_we)
         ram_q[ram_idx] <= mem_wdata;
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         fifo_q[tail_q] <= mem_wdata;
   end

   assign mem_rdata      = rdata_q;
   assign tx_valid       = (count_q != '0);
   assign tx_byte        = fifo_q[head_q];
   assign io_buffer_full = (count_q >= FULL_C);
   assign overflow       = ovf_q;
   assign sim_halt       = halt_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: RAM latency/aliasing, FIFO fill/overflow,
// simultaneous push/pop, halt flag and reset behaviour.
module tb_mem_responder;

   localparam logic [31:0] IO_BASE = 32'h0003_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        io_buffer_full;
   logic [7:0]  tx_byte;
   logic        tx_valid;
   logic        tx_ready;
   logic        overflow;
   logic        sim_halt;

   int unsigned n_eval = 0;
   int unsigned n_fail = 0;

   mem_responder #(
      .ADDR_WIDTH(17),
      .IO_BASE(IO_BASE),
      .FIFO_DEPTH(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .mem_a(mem_a),
      .mem_wr(mem_wr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .io_buffer_full(io_buffer_full),
      .tx_byte(tx_byte),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .overflow(overflow),
      .sim_halt(sim_halt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_eval++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      mem_a     = IO_BASE + 32'd8;
      mem_wr    = 1'b0;
      mem_wdata = 8'h00;
   endtask

   task automatic wr(input logic [31:0] a, input logic [7:0] d);
      mem_a     = a;
      mem_wr    = 1'b1;
      mem_wdata = d;
      cyc();
   endtask

   task automatic rd(input logic [31:0] a);
      mem_a  = a;
      mem_wr = 1'b0;
      cyc();
   endtask

   logic [7:0] exp_drain [8];

   initial begin
      reset    = 1'b1;
      tx_ready = 1'b0;
      idle();
      #3;
      chk("rst_rdata", mem_rdata, 8'h00);
      chk("rst_valid", {7'd0, tx_valid}, 8'h00);
      chk("rst_full", {7'd0, io_buffer_full}, 8'h00);
      chk("rst_ovf", {7'd0, overflow}, 8'h00);
      chk("rst_halt", {7'd0, sim_halt}, 8'h00);
      cyc();
      reset = 1'b0;
      cyc();

      // RAM write then read with 1-cycle latency; rdata holds during the write.
      wr(32'h0000_0010, 8'hA5);
      chk("wr_hold_rdata", mem_rdata, 8'h00);
      rd(32'h0000_0010);
      chk("ram_rd_a5", mem_rdata, 8'hA5);

      wr(32'h0000_0100, 8'h11);
      wr(32'h0000_0101, 8'h22);
      wr(32'h0000_0102, 8'h33);
      wr(32'h0000_0103, 8'h44);
      rd(32'h0000_0100); chk("b2b_0", mem_rdata, 8'h11);
      rd(32'h0000_0101); chk("b2b_1", mem_rdata, 8'h22);
      rd(32'h0000_0102); chk("b2b_2", mem_rdata, 8'h33);
      rd(32'h0000_0103); chk("b2b_3", mem_rdata, 8'h44);

      rd(32'h0002_0010); chk("alias_rd", mem_rdata, 8'hA5);
      wr(IO_BASE - 32'd1, 8'h5C);
      rd(IO_BASE - 32'd1); chk("below_io_ram", mem_rdata, 8'h5C);
      rd(IO_BASE);         chk("io_rd_zero", mem_rdata, 8'h00);

      // Fill FIFO with the sink stalled.
      for (int unsigned i = 1; i <= 6; i++) begin
         wr(IO_BASE, 8'(i));
         if (i == 5) chk("full_at5", {7'd0, io_buffer_full}, 8'h00);
      end
      chk("full_at6", {7'd0, io_buffer_full}, 8'h01);
      chk("head_first", tx_byte, 8'h01);
      wr(IO_BASE, 8'h07);
      wr(IO_BASE, 8'h08);
      chk("ovf_at8", {7'd0, overflow}, 8'h00);
      wr(IO_BASE, 8'h09);
      chk("ovf_at9", {7'd0, overflow}, 8'h01);
      idle();
      tx_ready = 1'b1;
      for (int unsigned i = 1; i <= 8; i++) begin
         chk("drain_valid", {7'd0, tx_valid}, 8'h01);
         chk("drain_byte", tx_byte, 8'(i));
         cyc();
      end
      chk("drain_empty", {7'd0, tx_valid}, 8'h00);
      chk("ovf_sticky", {7'd0, overflow}, 8'h01);

      reset = 1'b1;
      tx_ready = 1'b0;
      cyc();
      reset = 1'b0;
      chk("ovf_cleared", {7'd0, overflow}, 8'h00);
      for (int unsigned i = 0; i < 8; i++)
         wr(IO_BASE, 8'(8'h10 + i));
      chk("refill_full", {7'd0, io_buffer_full}, 8'h01);

      // Push into a full FIFO while the head is popped.
      tx_ready  = 1'b1;
      mem_a     = IO_BASE;
      mem_wr    = 1'b1;
      mem_wdata = 8'h7E;
      #1;
      chk("pp_head", tx_byte, 8'h10);
      cyc();
      idle();
      chk("pp_no_ovf", {7'd0, overflow}, 8'h00);
      for (int unsigned i = 0; i < 7; i++)
         exp_drain[i] = 8'(8'h11 + i);
      exp_drain[7] = 8'h7E;
      for (int unsigned i = 0; i < 8; i++) begin
         chk("pp_valid", {7'd0, tx_valid}, 8'h01);
         chk("pp_byte", tx_byte, exp_drain[i]);
         cyc();
      end
      chk("pp_empty", {7'd0, tx_valid}, 8'h00);

      // Halt flag; other I/O addresses ignored.
      tx_ready = 1'b0;
      wr(IO_BASE + 32'd4, 8'h55);
      chk("halt_set", {7'd0, sim_halt}, 8'h01);
      chk("halt_no_push", {7'd0, tx_valid}, 8'h00);
      wr(IO_BASE + 32'd8, 8'h66);
      chk("other_io_nop", {7'd0, tx_valid}, 8'h00);
      rd(32'h0000_0010); chk("pre_io_rd", mem_rdata, 8'hA5);
      rd(IO_BASE);       chk("io_rd_zero2", mem_rdata, 8'h00);

      // Reset in the middle of a drain.
      wr(IO_BASE, 8'hC1);
      wr(IO_BASE, 8'hC2);
      wr(IO_BASE, 8'hC3);
      rd(32'h0000_0103);
      tx_ready = 1'b1;
      cyc();
      chk("mid_drain_head", tx_byte, 8'hC2);
      reset = 1'b1;
      #1;
      chk("arst_halt", {7'd0, sim_halt}, 8'h00);
      chk("arst_valid", {7'd0, tx_valid}, 8'h00);
      chk("arst_rdata", mem_rdata, 8'h00);
      cyc();
      reset = 1'b0;
      cyc();
      chk("post_rst_valid", {7'd0, tx_valid}, 8'h00);
      rd(32'h0000_0010);  chk("keep_ram_10", mem_rdata, 8'hA5);
      rd(32'h0000_0103);  chk("keep_ram_103", mem_rdata, 8'h44);
      rd(IO_BASE - 32'd1); chk("keep_ram_top", mem_rdata, 8'h5C);

      $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
      $finish;
   end

endmodule
